// File: rtl/alu_share_arb.sv
// Time-shares one combinational ALU among NREQ requesters: IDLE grant, EXEC capture, RESP handshake.
// Optional macro ALU_SHARE_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
//
// state | meaning
// IDLE  | no operation in flight; req_ready offered to the arbitration winner
// EXEC  | latched operands drive the ALU; result captured at end of cycle
// RESP  | resp_valid held to the granted requester until its resp_ready
module alu_share_arb #(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*4-1:0]  req_f,
    input  logic [NREQ*5-1:0]  req_shamt,
    output logic [NREQ-1:0]    resp_valid,
    input  logic [NREQ-1:0]    resp_ready,
    output logic [31:0]        resp_y,
    output logic               resp_err,
    output logic               busy,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [3:0]         alu_f,
    output logic [4:0]         alu_shamt,
    input  logic [31:0]        alu_y
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] gnt;
    logic [IW-1:0] winner;
    logic          found;
    logic          accept;

    function automatic logic f_unsupported(input logic [3:0] f);
        case (f)
            4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
            4'b0110, 4'b0111, 4'b0011, 4'b1110: f_unsupported = 1'b0;
            default:                            f_unsupported = 1'b1;
        endcase
    endfunction

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest asserted index is the last (winning) assignment.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                winner = IW'(k);
                found  = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] rr;
    logic [IW-1:0] idx;
    logic [IW-1:0] rr_next;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign rr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
`endif

    assign accept    = (state == IDLE) && found;
    assign req_ready = accept ? (NREQ'(1) << winner) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            resp_valid <= '0;
            resp_y     <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_f      <= '0;
            alu_shamt  <= '0;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
            rr         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt       <= winner;
                        alu_a     <= req_a[32*winner +: 32];
                        alu_b     <= req_b[32*winner +: 32];
                        alu_f     <= req_f[4*winner +: 4];
                        alu_shamt <= req_shamt[5*winner +: 5];
                        busy      <= 1'b1;
                        state     <= EXEC;
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
                        rr        <= rr_next;
`endif
                    end
                end
                EXEC: begin
                    resp_y     <= alu_y;
                    resp_err   <= f_unsupported(alu_f);
                    resp_valid <= NREQ'(1) << gnt;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready[gnt]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
